// File: rtl/twos_to_signmag_pkg.sv
// Shared ALU definitions for the two's-complement to sign-magnitude converter:
// default operand/digit widths and the controller state encoding.
package twos_to_signmag_pkg;

  localparam int DEF_WIDTH   = 64;
  localparam int DEF_DIGIT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fa_cell.sv
// Full-adder cell wired to add an inverted operand bit to the incoming carry.
module fa_cell (
  input  logic a,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = ~a ^ c_in;
  assign c_out = ~a & c_in;

endmodule

// File: rtl/negate_digit.sv
// Ripple of full-adder cells producing (~a) + c_in for one digit.
module negate_digit
  import twos_to_signmag_pkg::*;
#(
  parameter int DIGIT_W = DEF_DIGIT_W
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic               c_in,
  output logic [DIGIT_W-1:0] sum,
  output logic               c_out
);

  logic [DIGIT_W:0] carry;

  assign carry[0] = c_in;
  assign c_out    = carry[DIGIT_W];

  for (genvar i = 0; i < DIGIT_W; i++) begin : g_cell
    fa_cell u_fa (
      .a    (a[i]),
      .c_in (carry[i]),
      .sum  (sum[i]),
      .c_out(carry[i+1])
    );
  end

endmodule

// File: rtl/twos_to_signmag.sv
// Digit-serial two's-complement to sign-magnitude converter; one digit per
// cycle LSB first, fixed latency of WIDTH/DIGIT_W cycles, valid/ready on both sides.
module twos_to_signmag
  import twos_to_signmag_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DIGIT_W = DEF_DIGIT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_ovf
);

  localparam int NDIG  = WIDTH / DIGIT_W;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   operand_q, operand_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               sign_q, sign_d;

  logic [DIGIT_W-1:0] digit, negSum, digitRes;
  logic               negCout;
  logic [WIDTH-1:0]   digitExt;

  assign digit = operand_q[DIGIT_W-1:0];

  negate_digit #(.DIGIT_W(DIGIT_W)) u_neg (
    .a    (digit),
    .c_in (carry_q),
    .sum  (negSum),
    .c_out(negCout)
  );

  assign digitRes = sign_q ? negSum : digit;
  assign digitExt = WIDTH'(digitRes);

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    result_d  = result_q;
    carry_d   = carry_q;
    count_d   = count_q;
    sign_d    = sign_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          operand_d = in_data;
          sign_d    = in_data[WIDTH-1];
          count_d   = '0;
          carry_d   = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        // New digit enters at the top so the result is aligned after NDIG shifts.
        operand_d = operand_q >> DIGIT_W;
        result_d  = (result_q >> DIGIT_W) | (digitExt << (WIDTH - DIGIT_W));
        if (sign_q) carry_d = negCout;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(NDIG - 1)) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      operand_q <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      count_q   <= '0;
      sign_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      count_q   <= count_d;
      sign_q    <= sign_d;
    end
  end

  assign out_sign = sign_q;
  assign out_mag  = result_q;
  assign out_ovf  = sign_q & result_q[WIDTH-1];

endmodule
